// File: rtl/mdpram_ctrl.sv
// mdpram_ctrl: requester-side controller for a 2R+2W read-first multiport RAM with tagged, credit-limited reads.
// Optional feature macro MDPRAM_CTRL_BYPASS_EN: same-cycle write data is forwarded into the read response.
module mdpram_ctrl #(
    parameter int unsigned DEPTH     = 1000,
    parameter int unsigned WIDTH     = 17,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned NUM_WR    = 2,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD-1:0]            rd_req_valid,
    output logic [NUM_RD-1:0]            rd_req_ready,
    input  logic [NUM_RD-1:0][AW-1:0]    rd_req_addr,
    input  logic [NUM_RD-1:0][TAG_W-1:0] rd_req_tag,
    output logic [NUM_RD-1:0]            rd_rsp_valid,
    input  logic [NUM_RD-1:0]            rd_rsp_ready,
    output logic [NUM_RD-1:0][WIDTH-1:0] rd_rsp_data,
    output logic [NUM_RD-1:0][TAG_W-1:0] rd_rsp_tag,
    input  logic [NUM_WR-1:0]            wr_req_valid,
    output logic [NUM_WR-1:0]            wr_req_ready,
    input  logic [NUM_WR-1:0][AW-1:0]    wr_req_addr,
    input  logic [NUM_WR-1:0][WIDTH-1:0] wr_req_data,
    output logic [NUM_RD-1:0][AW-1:0]    ram_raddr,
    output logic [NUM_RD-1:0]            ram_ren,
    input  logic [NUM_RD-1:0][WIDTH-1:0] ram_rdata,
    output logic [NUM_WR-1:0][AW-1:0]    ram_waddr,
    output logic [NUM_WR-1:0]            ram_wen,
    output logic [NUM_WR-1:0][WIDTH-1:0] ram_wdata
);
    localparam int unsigned PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(RSP_DEPTH + 1);
    localparam int unsigned ENT_W = TAG_W + WIDTH;

    if (RD_LAT < 1) begin : g_chk_lat
        $fatal(1, "mdpram_ctrl: RD_LAT must be >= 1");
    end
    if (NUM_RD != 2 || NUM_WR != 2) begin : g_chk_ports
        $fatal(1, "mdpram_ctrl: NUM_RD and NUM_WR must both be 2");
    end
    if (RSP_DEPTH < 2) begin : g_chk_fifo
        $fatal(1, "mdpram_ctrl: RSP_DEPTH must be >= 2");
    end

    // Same-address write pair: port 0 goes now, port 1 waits a cycle so its data lands last.
    assign wr_req_ready[0] = !rst;
    assign wr_req_ready[1] = !rst && !(wr_req_valid[0] && (wr_req_addr[0] == wr_req_addr[1]));
    assign ram_wen         = wr_req_valid & wr_req_ready;
    assign ram_waddr       = wr_req_addr;
    assign ram_wdata       = wr_req_data;

    assign ram_ren   = {NUM_RD{!rst}};
    assign ram_raddr = rd_req_addr;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [RD_LAT-1:0]               vld_q, vld_d;
        logic [RD_LAT-1:0][TAG_W-1:0]    tag_q, tag_d;
        logic [RSP_DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
        logic [PW-1:0]                   wptr_q, wptr_d, rptr_q, rptr_d;
        logic [CW-1:0]                   cnt_q, cnt_d, out_q, out_d;
        logic                            accept, pop, push;
        logic [WIDTH-1:0]                push_data;

        // Credits cover both the RAM pipe and the FIFO, so a push always finds room.
        assign rd_req_ready[i] = !rst && (out_q < CW'(RSP_DEPTH));
        assign rd_rsp_valid[i] = !rst && (cnt_q != '0);
        assign accept          = rd_req_valid[i] && rd_req_ready[i];
        assign pop             = rd_rsp_valid[i] && rd_rsp_ready[i];
        assign push            = vld_q[RD_LAT-1];
        assign {rd_rsp_tag[i], rd_rsp_data[i]} = mem_q[rptr_q];

`ifdef MDPRAM_CTRL_BYPASS_EN
        logic [RD_LAT-1:0]            byp_q, byp_d;
        logic [RD_LAT-1:0][WIDTH-1:0] bdat_q, bdat_d;

        always_comb begin
            byp_d     = byp_q;
            bdat_d    = bdat_q;
            byp_d[0]  = 1'b0;
            bdat_d[0] = ram_wdata[0];
            if (ram_wen[1] && (ram_waddr[1] == rd_req_addr[i])) begin
                byp_d[0]  = 1'b1;
                bdat_d[0] = ram_wdata[1];
            end else if (ram_wen[0] && (ram_waddr[0] == rd_req_addr[i])) begin
                byp_d[0]  = 1'b1;
            end
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                byp_d[k]  = byp_q[k-1];
                bdat_d[k] = bdat_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) byp_q <= '0;
            else     byp_q <= byp_d;
            bdat_q <= bdat_d;
        end

        assign push_data = byp_q[RD_LAT-1] ? bdat_q[RD_LAT-1] : ram_rdata[i];
`else
        assign push_data = ram_rdata[i];
`endif

        always_comb begin
            vld_d    = vld_q;
            tag_d    = tag_q;
            vld_d[0] = accept;
            tag_d[0] = rd_req_tag[i];
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            mem_d  = mem_q;
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            if (push) begin
                mem_d[wptr_q] = {tag_q[RD_LAT-1], push_data};
                wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            out_d = out_q + CW'(accept) - CW'(pop);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                out_q  <= '0;
            end else begin
                vld_q  <= vld_d;
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
                out_q  <= out_d;
            end
        end

        always_ff @(posedge clk) begin
            tag_q <= tag_d;
            mem_q <= mem_d;
        end

        a_rd_addr_range: assert property (@(posedge clk) disable iff (rst)
            accept |-> (32'(rd_req_addr[i]) < DEPTH))
            else $error("mdpram_ctrl: read address out of range on port %0d", i);
    end
endmodule

// File: tb/tb_mdpram_ctrl.sv
// Bench for mdpram_ctrl: behavioural 2R+2W read-first RAM, scoreboard queues per read port, directed and random traffic.
module tb_mdpram_ctrl;
    localparam int RD_LAT    = 3;
    localparam int RSP_DEPTH = 4;

    logic              clk, rst;
    logic [1:0]        rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready;
    logic [1:0][9:0]   rd_req_addr, ram_raddr, wr_req_addr, ram_waddr;
    logic [1:0][3:0]   rd_req_tag, rd_rsp_tag;
    logic [1:0][16:0]  rd_rsp_data, ram_rdata, wr_req_data, ram_wdata;
    logic [1:0]        wr_req_valid, wr_req_ready, ram_ren, ram_wen;

    int                errors = 0;
    int                checks = 0;
    bit                auto_sb = 0;
    int                out_m [2];
    logic [20:0]       q0 [$];
    logic [20:0]       q1 [$];
    logic [16:0]       shadow  [1024];
    logic [16:0]       ram_mem [1024];
    logic [16:0]       rpipe0 [RD_LAT];
    logic [16:0]       rpipe1 [RD_LAT];

    mdpram_ctrl #(
        .DEPTH(1000), .WIDTH(17), .RD_LAT(RD_LAT), .NUM_RD(2), .NUM_WR(2), .TAG_W(4), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data), .rd_rsp_tag(rd_rsp_tag),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
        .ram_waddr(ram_waddr), .ram_wen(ram_wen), .ram_wdata(ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM: pipelines sample old contents, writes land at the same edge (port 1 last).
    always @(posedge clk) begin
        if (ram_ren[0]) begin
            rpipe0[0] <= ram_mem[ram_raddr[0]];
            for (int k = 1; k < RD_LAT; k++) rpipe0[k] <= rpipe0[k-1];
        end
        if (ram_ren[1]) begin
            rpipe1[0] <= ram_mem[ram_raddr[1]];
            for (int k = 1; k < RD_LAT; k++) rpipe1[k] <= rpipe1[k-1];
        end
        if (ram_wen[0]) ram_mem[ram_waddr[0]] <= ram_wdata[0];
        if (ram_wen[1]) ram_mem[ram_waddr[1]] <= ram_wdata[1];
    end
    assign ram_rdata[0] = rpipe0[RD_LAT-1];
    assign ram_rdata[1] = rpipe1[RD_LAT-1];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input int p, input logic [3:0] t, input logic [16:0] d);
        if (p == 0) q0.push_back({t, d});
        else        q1.push_back({t, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request-side observer: credit model, write arbitration, pass-through, shadow memory for random traffic.
    always @(negedge clk) begin
        logic [1:0]  wacc;
        logic [16:0] exp_d;
        if (rst) begin
            out_m[0] = 0;
            out_m[1] = 0;
            q0.delete();
            q1.delete();
        end else begin
            wacc = wr_req_valid & wr_req_ready;
            for (int p = 0; p < 2; p++)
                chk($sformatf("rd_req_ready%0d", p), rd_req_ready[p], (out_m[p] < RSP_DEPTH) ? 1 : 0);
            chk("wr_req_ready0", wr_req_ready[0], 1);
            chk("wr_req_ready1", wr_req_ready[1],
                (wr_req_valid[0] && wr_req_addr[0] == wr_req_addr[1]) ? 0 : 1);
            chk("ram_wen", ram_wen, wacc);
            chk("ram_ren", ram_ren, 3);
            chk("ram_raddr", ram_raddr, rd_req_addr);
            chk("ram_waddr", ram_waddr, wr_req_addr);
            for (int p = 0; p < 2; p++) begin
                if (rd_req_valid[p] && rd_req_ready[p]) begin
                    out_m[p]++;
                    if (auto_sb) begin
                        exp_d = shadow[rd_req_addr[p]];
`ifdef MDPRAM_CTRL_BYPASS_EN
                        if (wacc[1] && wr_req_addr[1] == rd_req_addr[p]) exp_d = wr_req_data[1];
                        else if (wacc[0] && wr_req_addr[0] == rd_req_addr[p]) exp_d = wr_req_data[0];
`endif
                        sb_push(p, rd_req_tag[p], exp_d);
                    end
                end
                if (rd_rsp_valid[p] && rd_rsp_ready[p]) out_m[p]--;
            end
            if (wacc[0]) shadow[wr_req_addr[0]] = wr_req_data[0];
            if (wacc[1]) shadow[wr_req_addr[1]] = wr_req_data[1];
        end
    end

    // Response monitor: every consumed response must match the head of its port's queue.
    always @(negedge clk) begin
        logic [20:0] e;
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (rd_rsp_valid[p] && rd_rsp_ready[p]) begin
                    checks++;
                    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                        errors++;
                        $display("FAIL rsp%0d_unexpected: got tag=%0h data=%0h, required no response",
                                 p, rd_rsp_tag[p], rd_rsp_data[p]);
                    end else begin
                        if (p == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        if ({rd_rsp_tag[p], rd_rsp_data[p]} !== e) begin
                            errors++;
                            $display("FAIL rsp%0d: got tag=%0h data=%0h, required tag=%0h data=%0h",
                                     p, rd_rsp_tag[p], rd_rsp_data[p], e[20:17], e[16:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic rd_issue(input int p, input logic [9:0] a, input logic [3:0] t, input logic [16:0] d);
        int n = 0;
        rd_req_valid[p] = 1'b1;
        rd_req_addr[p]  = a;
        rd_req_tag[p]   = t;
        @(negedge clk);
        while (!rd_req_ready[p] && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rd_req_ready[p]) begin
            errors++;
            $display("FAIL rd_issue%0d_timeout: got ready=0, required ready=1 within 20 cycles", p);
        end else begin
            sb_push(p, t, d);
        end
        tick();
        rd_req_valid[p] = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        rd_req_valid = '0;
        wr_req_valid = '0;
        rd_rsp_ready = '1;
        while ((q0.size() + q1.size()) != 0 && n < 60) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk("drain_empty", q0.size() + q1.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, idx;
        for (int k = 0; k < 1024; k++) begin
            shadow[k]  = '0;
            ram_mem[k] = '0;
        end
        for (int k = 0; k < RD_LAT; k++) begin
            rpipe0[k] = '0;
            rpipe1[k] = '0;
        end
        rst          = 1'b1;
        rd_req_valid = 2'b11;
        wr_req_valid = 2'b11;
        rd_rsp_ready = 2'b11;
        rd_req_addr  = '0;
        rd_req_tag   = '0;
        wr_req_addr  = '0;
        wr_req_data  = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_rd_req_ready", rd_req_ready, 0);
        chk("reset_wr_req_ready", wr_req_ready, 0);
        chk("reset_rd_rsp_valid", rd_rsp_valid, 0);
        chk("reset_ram_ren", ram_ren, 0);
        chk("reset_ram_wen", ram_wen, 0);
        tick();
        rst          = 1'b0;
        rd_req_valid = '0;
        wr_req_valid = '0;

        // Write then read on the other port; response appears RD_LAT+1 cycles after accept.
        wr_req_valid[0] = 1'b1;
        wr_req_addr[0]  = 10'd5;
        wr_req_data[0]  = 17'h1ABCD;
        tick();
        wr_req_valid[0] = 1'b0;
        rd_issue(1, 10'd5, 4'd3, 17'h1ABCD);
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            @(negedge clk);
            chk($sformatf("rsp_latency_c%0d", k), rd_rsp_valid[1], (k == RD_LAT + 1) ? 1 : 0);
            tick();
        end
        wait_empty();

        // Credit limit with response backpressure.
        for (int k = 0; k < 3; k++) begin
            wr_req_valid   = 2'b11;
            wr_req_addr[0] = 10'(20 + 2 * k);
            wr_req_data[0] = 17'(32'h100 + 2 * k);
            wr_req_addr[1] = 10'(21 + 2 * k);
            wr_req_data[1] = 17'(32'h101 + 2 * k);
            tick();
        end
        wr_req_valid    = '0;
        rd_rsp_ready[0] = 1'b0;
        acc = 0;
        idx = 0;
        rd_req_valid[0] = 1'b1;
        rd_req_addr[0]  = 10'd20;
        rd_req_tag[0]   = 4'd0;
        repeat (8) begin
            @(negedge clk);
            if (rd_req_ready[0]) begin
                sb_push(0, 4'(idx), 17'(32'h100 + idx));
                acc++;
                idx++;
            end
            tick();
            rd_req_addr[0] = 10'(20 + idx);
            rd_req_tag[0]  = 4'(idx);
        end
        chk("credit_fill_count", acc, RSP_DEPTH);
        rd_rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("credit_full_ready", rd_req_ready[0], 0);
        chk("credit_full_rsp_valid", rd_rsp_valid[0], 1);
        tick();
        rd_rsp_ready[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rd_req_ready[0]) begin
                sb_push(0, 4'(idx), 17'(32'h100 + idx));
                acc++;
                idx++;
            end
            tick();
            rd_req_addr[0] = 10'(20 + idx);
            rd_req_tag[0]  = 4'(idx);
        end
        chk("credit_one_more", acc, RSP_DEPTH + 1);
        rd_rsp_ready[0] = 1'b1;
        for (int c = 0; c < 10 && idx < 6; c++) begin
            @(negedge clk);
            if (rd_req_ready[0]) begin
                sb_push(0, 4'(idx), 17'(32'h100 + idx));
                idx++;
            end
            tick();
            rd_req_addr[0] = 10'(20 + idx);
            rd_req_tag[0]  = 4'(idx);
        end
        chk("credit_all_six", idx, 6);
        wait_empty();

        // Same-address write collision: port 1 deferred one cycle and wins.
        wr_req_valid   = 2'b11;
        wr_req_addr[0] = 10'd7;
        wr_req_data[0] = 17'h11;
        wr_req_addr[1] = 10'd7;
        wr_req_data[1] = 17'h22;
        @(negedge clk);
        chk("collide_ready0", wr_req_ready[0], 1);
        chk("collide_ready1", wr_req_ready[1], 0);
        tick();
        wr_req_valid[0] = 1'b0;
        @(negedge clk);
        chk("collide_ready1_next", wr_req_ready[1], 1);
        tick();
        wr_req_valid = '0;
        rd_issue(0, 10'd7, 4'd7, 17'h22);
        wait_empty();

        // Read and write of the same address in one cycle.
        wr_req_valid[0] = 1'b1;
        wr_req_addr[0]  = 10'd9;
        wr_req_data[0]  = 17'h5;
        tick();
        wr_req_data[0]  = 17'h6;
`ifdef MDPRAM_CTRL_BYPASS_EN
        rd_issue(1, 10'd9, 4'd9, 17'h6);
`else
        rd_issue(1, 10'd9, 4'd9, 17'h5);
`endif
        wr_req_valid[0] = 1'b0;
        rd_issue(0, 10'd9, 4'd10, 17'h6);
        wait_empty();

        // Reset with reads in flight: nothing may emerge afterwards.
        rd_req_valid[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            rd_req_addr[0] = 10'(k);
            rd_req_tag[0]  = 4'(k);
            @(negedge clk);
            chk("flush_accept", rd_req_ready[0], 1);
            tick();
        end
        rd_req_valid[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("flush_no_rsp", rd_rsp_valid, 0);
            chk("flush_ready", rd_req_ready, 3);
            tick();
        end
        rd_issue(0, 10'd5, 4'hE, 17'h1ABCD);
        wait_empty();

        // Random traffic against the shadow-memory model.
        auto_sb = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rd_req_valid = 2'($urandom);
            rd_rsp_ready = 2'($urandom);
            wr_req_valid = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                rd_req_addr[p] = 10'($urandom_range(0, 15));
                rd_req_tag[p]  = 4'($urandom);
                wr_req_addr[p] = 10'($urandom_range(0, 15));
                wr_req_data[p] = 17'($urandom);
            end
            tick();
        end
        wait_empty();
        chk("final_outstanding0", out_m[0], 0);
        chk("final_outstanding1", out_m[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
